mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter for the single shared Memory port of the multicycle datapath. It accepts independent access requests from the instruction-fetch side and the load/store side, and grants one at a time with round-robin fairness. It holds the address and write strobe steady for the memory's fixed read latency. In the response cycle it pulses the load strobes for IR and MDR, and asserts the operand-B mux select so that `Memory_Out` feeds the ALU B input.

## Interface
- `MEM_LAT`, 1: read latency of the memory in cycles, from address valid to `mem_rdata` valid; legal range 1..7.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_fetch` in 1: fetch request; level, held until `done_fetch`.
- `fetch_addr` in 32: fetch address (PC); must be stable while `req_fetch` is high.
- `req_data` in 1: load/store request; level, held until `done_data`.
- `data_addr` in 32: load/store address; stable while `req_data` is high.
- `data_we` in 1: 1 = store, 0 = load; stable while `req_data` is high.
- `data_wdata` in 32: store data.
- `mem_addr` out 32: address to Memory.
- `mem_wr` out 1: Memory write strobe.
- `mem_wdata` out 32: Memory write data.
- `done_fetch` out 1: one-cycle completion pulse for fetch.
- `done_data` out 1: one-cycle completion pulse for load/store.
- `ir_write` out 1: IR load strobe, fetch response.
- `mdr_write` out 1: MDR load strobe, load response.
- `mux_b_sel` out 1: operand-B mux select (1 = `Memory_Out`, 0 = `Read_Data2_Out`).
- `busy` out 1: high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP. All outputs are registered.
- **IDLE**
  - `req_fetch` and `req_data` are sampled.
  - Only one request high: that requester is granted.
  - Both high: the requester not served last is granted.
  - The `last_grant` register resets to "data", so fetch wins the first tie after reset.
  - On grant: latch the owner, the address, `we` (forced to 0 for fetch) and `wdata`; load the counter; go to ACCESS.
  - No request: stay in IDLE.
- **ACCESS**
  - `mem_addr` = latched address and `busy`=1.
  - Write: `mem_wr`=1 and `mem_wdata` = latched data for exactly one cycle, then RESP.
  - Read: `mem_wr`=0; stay in ACCESS for MEM_LAT cycles (3-bit down-counter loaded with MEM_LAT-1), then RESP.
- **RESP**
  - `mem_addr` is held and `mem_wr`=0.
  - Fetch: `done_fetch`=1 and `ir_write`=1.
  - Load: `done_data`=1, `mdr_write`=1 and `mux_b_sel`=1.
  - Store: `done_data`=1 only.
  - Update `last_grant` to the owner; go to IDLE.
- **Requester rule**: drop `req` (or change to a new request) in the cycle after `done`. IDLE samples the following cycle, so back-to-back requests from the same requester lose one cycle.
- **Outputs in IDLE**: all strobes and `done`s are 0. `mem_addr` holds its last value; it is 0 after reset.
- **Reset**: while `reset_n`=0 at an edge, next state is IDLE.
  - All outputs go to 0: `mem_addr`=0, `mem_wr`=0, `mem_wdata`=0, `done_*`=0, `ir_write`=0, `mdr_write`=0, `mux_b_sel`=0, `busy`=0.
  - Counter is cleared and `last_grant`=data.
  - Reset in mid-ACCESS aborts the access; no `done` is issued, and the requester must re-request.
- Requests arriving while `busy` are ignored until the next IDLE. They are never lost as long as they are held.
- `mux_b_sel` is 0 at all times except load RESP cycles. The downstream mux treats 0 as `Read_Data2_Out`.

## Timing
- Cycle 0 (IDLE, request sampled) → ACCESS from cycle 1.
- Read: ACCESS covers cycles 1..MEM_LAT and RESP is at cycle MEM_LAT+1. `mem_rdata` is valid in RESP, aligned with `ir_write`/`mdr_write`.
- Write: ACCESS is cycle 1 (`mem_wr`=1) and RESP is cycle 2, independent of MEM_LAT.
- Throughput:
  - Read: one access per MEM_LAT+2 cycles.
  - Write: one access per 3 cycles.
- Output changes occur only at clock edges; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset**
  - Stimulus: hold `reset_n`=0 for 2 cycles with both requests high.
  - Response: all outputs 0, `busy`=0. After release, the first grant is fetch (`done_fetch` first).
- **Fetch read, MEM_LAT=2**
  - Stimulus: `req_fetch`=1, `fetch_addr`=0x00000040 at cycle 0.
  - Response: `mem_addr`=0x40 in cycles 1–3, `mem_wr`=0. `done_fetch`=`ir_write`=1 at cycle 3 only; `mux_b_sel`=0 throughout.
- **Load, MEM_LAT=2**
  - Stimulus: `req_data`=1, `data_we`=0, `data_addr`=0x100.
  - Response: `done_data`=`mdr_write`=`mux_b_sel`=1 at cycle 3 only.
- **Store**
  - Stimulus: `data_we`=1, `data_addr`=0x104, `data_wdata`=0xDEADBEEF.
  - Response: `mem_wr`=1 with `mem_wdata`=0xDEADBEEF at cycle 1 only; `done_data` at cycle 2; `mdr_write`=0.
- **Contention**
  - Stimulus: both requests held continuously, each dropped and re-raised one cycle after its `done`.
  - Response: grants alternate fetch, data, fetch, data. No requester is starved; `busy` never overlaps two owners.
- **Mid-access reset, MEM_LAT=3**
  - Stimulus: `reset_n`=0 in cycle 2 of a load.
  - Response: no `done_data`, `mem_addr`=0 next cycle, FSM in IDLE. A re-request completes normally, with `done_data` at cycle MEM_LAT+1 = 4.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch/load-store request side and the shared memory port
// side of mem_port_arbiter. The arbiter connects through the slave modport;
// the requesters and memory model connect through the master modport.
interface mem_port_arbiter_if;
  // Requester side
  logic        req_fetch;
  logic [31:0] fetch_addr;
  logic        req_data;
  logic [31:0] data_addr;
  logic        data_we;
  logic [31:0] data_wdata;

  // Memory port and datapath control side
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        done_fetch;
  logic        done_data;
  logic        ir_write;
  logic        mdr_write;
  logic        mux_b_sel;
  logic        busy;

  modport slave (
    input  req_fetch, fetch_addr, req_data, data_addr, data_we, data_wdata,
    output mem_addr, mem_wr, mem_wdata, done_fetch, done_data,
           ir_write, mdr_write, mux_b_sel, busy
  );

  modport master (
    output req_fetch, fetch_addr, req_data, data_addr, data_we, data_wdata,
    input  mem_addr, mem_wr, mem_wdata, done_fetch, done_data,
           ir_write, mdr_write, mux_b_sel, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and access sequencer for the single shared memory port.
// Grants fetch or load/store one at a time, holds the address for the memory
// read latency, and pulses the IR/MDR load strobes in the response cycle.
// Every output is a flop; next values are computed from the state transition.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 32'd1
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  // Down-counter start value: a read spends MEM_LAT cycles in ACCESS.
  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 32'd1);

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;

  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_fetch_q, done_fetch_d;
  logic        done_data_q, done_data_d;
  logic        ir_write_q, ir_write_d;
  logic        mdr_write_q, mdr_write_d;
  logic        mux_b_sel_q, mux_b_sel_d;
  logic        busy_q, busy_d;

  logic        gnt_valid_s;
  logic        gnt_data_s;
  logic [31:0] gnt_addr_s;
  logic        gnt_we_s;
  logic [31:0] gnt_wdata_s;

  // Pick the winner among current requests; on a tie the side not served last wins.
  always_comb begin
    gnt_valid_s = bus.req_fetch | bus.req_data;
    if (bus.req_fetch && bus.req_data) begin
      gnt_data_s = (last_grant_q == OWN_FETCH);
    end else if (bus.req_data) begin
      gnt_data_s = 1'b1;
    end else begin
      gnt_data_s = 1'b0;
    end
    if (gnt_data_s) begin
      gnt_addr_s  = bus.data_addr;
      gnt_we_s    = bus.data_we;
      gnt_wdata_s = bus.data_wdata;
    end else begin
      // Fetches never write memory.
      gnt_addr_s  = bus.fetch_addr;
      gnt_we_s    = 1'b0;
      gnt_wdata_s = 32'd0;
    end
  end

  // Sequencer: next state, latched request and next output values.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;

    // Strobes default low; the address holds its last value when idle.
    mem_addr_d   = mem_addr_q;
    mem_wr_d     = 1'b0;
    mem_wdata_d  = 32'd0;
    done_fetch_d = 1'b0;
    done_data_d  = 1'b0;
    ir_write_d   = 1'b0;
    mdr_write_d  = 1'b0;
    mux_b_sel_d  = 1'b0;
    busy_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt_valid_s) begin
          state_d     = S_ACCESS;
          owner_d     = gnt_data_s ? OWN_DATA : OWN_FETCH;
          we_d        = gnt_we_s;
          addr_d      = gnt_addr_s;
          wdata_d     = gnt_wdata_s;
          cnt_d       = LAT_LOAD;
          mem_addr_d  = gnt_addr_s;
          busy_d      = 1'b1;
          // A store drives the write strobe only in its single ACCESS cycle.
          mem_wr_d    = gnt_we_s;
          mem_wdata_d = gnt_we_s ? gnt_wdata_s : 32'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ACCESS: begin
        mem_addr_d = addr_q;
        busy_d     = 1'b1;
        if (we_q || (cnt_q == 3'd0)) begin
          state_d = S_RESP;
          cnt_d   = 3'd0;
          if (owner_q == OWN_FETCH) begin
            done_fetch_d = 1'b1;
            ir_write_d   = 1'b1;
          end else if (we_q) begin
            done_data_d = 1'b1;
          end else begin
            // Load data lands in MDR and is steered onto ALU operand B.
            done_data_d = 1'b1;
            mdr_write_d = 1'b1;
            mux_b_sel_d = 1'b1;
          end
        end else begin
          state_d = S_ACCESS;
          cnt_d   = cnt_q - 3'd1;
        end
      end

      S_RESP: begin
        state_d      = S_IDLE;
        last_grant_d = owner_q;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_FETCH;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      cnt_q        <= 3'd0;
      last_grant_q <= OWN_DATA;
      mem_addr_q   <= 32'd0;
      mem_wr_q     <= 1'b0;
      mem_wdata_q  <= 32'd0;
      done_fetch_q <= 1'b0;
      done_data_q  <= 1'b0;
      ir_write_q   <= 1'b0;
      mdr_write_q  <= 1'b0;
      mux_b_sel_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wr_q     <= mem_wr_d;
      mem_wdata_q  <= mem_wdata_d;
      done_fetch_q <= done_fetch_d;
      done_data_q  <= done_data_d;
      ir_write_q   <= ir_write_d;
      mdr_write_q  <= mdr_write_d;
      mux_b_sel_q  <= mux_b_sel_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.done_fetch = done_fetch_q;
  assign bus.done_data  = done_data_q;
  assign bus.ir_write   = ir_write_q;
  assign bus.mdr_write  = mdr_write_q;
  assign bus.mux_b_sel  = mux_b_sel_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two instances (MEM_LAT=2 and 3).
// Stimulus pushes expected completions/writes into per-instance queues; a
// monitor pops and compares whenever an instance shows a grant, a write or a done.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst2_n;
  logic rst3_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Clock generator.
  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if bus2();
  mem_port_arbiter_if bus3();

  mem_port_arbiter #(.MEM_LAT(2)) dut2 (.clk(clk), .reset_n(rst2_n), .bus(bus2));
  mem_port_arbiter #(.MEM_LAT(3)) dut3 (.clk(clk), .reset_n(rst3_n), .bus(bus3));

  typedef struct {
    bit          fetch;
    bit          load;
    bit          store;
    logic [31:0] addr;
    int          lat;   // cycles from first busy cycle to done
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
  } wr_t;

  exp_t sq[2][$];
  wr_t  wq[2][$];
  int   busy_start[2];
  logic busy_prev[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic mon_step(input int id, input logic [31:0] maddr, input logic mwr,
                          input logic [31:0] mwdata, input logic df, input logic dd,
                          input logic irw, input logic mdw, input logic mbs, input logic bsy);
    exp_t e;
    wr_t  w;
    if (bsy === 1'b1 && busy_prev[id] !== 1'b1) begin
      busy_start[id] = cyc;
      if (sq[id].size() == 0) begin
        total++; bad++;
        $display("FAIL grant_%0d: unexpected grant at addr 0x%08h", id, maddr);
      end else begin
        check($sformatf("grant_addr_%0d", id), maddr, sq[id][0].addr);
      end
    end
    busy_prev[id] = bsy;

    if (mwr === 1'b1) begin
      if (wq[id].size() == 0) begin
        total++; bad++;
        $display("FAIL write_%0d: unexpected mem_wr addr 0x%08h data 0x%08h", id, maddr, mwdata);
      end else begin
        w = wq[id].pop_front();
        check($sformatf("wr_addr_%0d", id), maddr, w.addr);
        check($sformatf("wr_data_%0d", id), mwdata, w.wdata);
        check($sformatf("wr_cycle_%0d", id), cyc - busy_start[id], 0);
      end
    end

    if (df === 1'b1 || dd === 1'b1) begin
      if (sq[id].size() == 0) begin
        total++; bad++;
        $display("FAIL done_%0d: unexpected done fetch=%0b data=%0b", id, df, dd);
      end else begin
        e = sq[id].pop_front();
        check($sformatf("done_fetch_%0d", id), {31'd0, df}, {31'd0, e.fetch});
        check($sformatf("done_data_%0d", id), {31'd0, dd}, {31'd0, e.load | e.store});
        check($sformatf("ir_write_%0d", id), {31'd0, irw}, {31'd0, e.fetch});
        check($sformatf("mdr_write_%0d", id), {31'd0, mdw}, {31'd0, e.load});
        check($sformatf("mux_b_sel_%0d", id), {31'd0, mbs}, {31'd0, e.load});
        check($sformatf("resp_addr_%0d", id), maddr, e.addr);
        check($sformatf("resp_wr_%0d", id), {31'd0, mwr}, 32'd0);
        check($sformatf("resp_busy_%0d", id), {31'd0, bsy}, 32'd1);
        check($sformatf("latency_%0d", id), cyc - busy_start[id], e.lat);
      end
    end else begin
      check($sformatf("strobes_quiet_%0d", id), {29'd0, irw, mdw, mbs}, 32'd0);
    end
  endtask

  // Monitor: samples both instances on the falling edge.
  initial begin
    busy_prev[0] = 1'b0;
    busy_prev[1] = 1'b0;
    forever begin
      @(negedge clk);
      mon_step(0, bus2.mem_addr, bus2.mem_wr, bus2.mem_wdata, bus2.done_fetch, bus2.done_data,
               bus2.ir_write, bus2.mdr_write, bus2.mux_b_sel, bus2.busy);
      mon_step(1, bus3.mem_addr, bus3.mem_wr, bus3.mem_wdata, bus3.done_fetch, bus3.done_data,
               bus3.ir_write, bus3.mdr_write, bus3.mux_b_sel, bus3.busy);
    end
  end

  // Fetch requester on the MEM_LAT=2 instance; returns negedges until done_fetch.
  task automatic fetch_job(input logic [31:0] a, output int waited);
    bus2.fetch_addr = a;
    bus2.req_fetch  = 1'b1;
    waited = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus2.done_fetch === 1'b1) begin
        waited = i;
        break;
      end
    end
    bus2.req_fetch = 1'b0;
    if (waited < 0) begin
      total++; bad++;
      $display("FAIL fetch_timeout: no done_fetch for addr 0x%08h within 40 cycles", a);
    end
  endtask

  // Load/store requester on instance id; returns negedges until done_data.
  task automatic data_job(input int id, input logic [31:0] a, input logic we,
                          input logic [31:0] wd, output int waited);
    logic d;
    if (id == 0) begin
      bus2.data_addr = a; bus2.data_we = we; bus2.data_wdata = wd; bus2.req_data = 1'b1;
    end else begin
      bus3.data_addr = a; bus3.data_we = we; bus3.data_wdata = wd; bus3.req_data = 1'b1;
    end
    waited = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      d = (id == 0) ? bus2.done_data : bus3.done_data;
      if (d === 1'b1) begin
        waited = i;
        break;
      end
    end
    if (id == 0) bus2.req_data = 1'b0;
    else         bus3.req_data = 1'b0;
    if (waited < 0) begin
      total++; bad++;
      $display("FAIL data_timeout_%0d: no done_data for addr 0x%08h within 40 cycles", id, a);
    end
  endtask

  int wf1, wf2, wd1, wd2;

  // Directed stimulus.
  initial begin
    rst2_n = 1'b0;
    rst3_n = 1'b0;
    bus2.req_fetch = 1'b0; bus2.fetch_addr = 32'd0; bus2.req_data = 1'b0;
    bus2.data_addr = 32'd0; bus2.data_we = 1'b0; bus2.data_wdata = 32'd0;
    bus3.req_fetch = 1'b0; bus3.fetch_addr = 32'd0; bus3.req_data = 1'b0;
    bus3.data_addr = 32'd0; bus3.data_we = 1'b0; bus3.data_wdata = 32'd0;

    // Reset held two cycles with both requests up.
    bus2.fetch_addr = 32'h0000_0200; bus2.req_fetch = 1'b1;
    bus2.data_addr  = 32'h0000_0300; bus2.req_data  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mem_addr",   bus2.mem_addr, 32'd0);
    check("rst_mem_wr",     {31'd0, bus2.mem_wr}, 32'd0);
    check("rst_mem_wdata",  bus2.mem_wdata, 32'd0);
    check("rst_done_fetch", {31'd0, bus2.done_fetch}, 32'd0);
    check("rst_done_data",  {31'd0, bus2.done_data}, 32'd0);
    check("rst_ir_write",   {31'd0, bus2.ir_write}, 32'd0);
    check("rst_mdr_write",  {31'd0, bus2.mdr_write}, 32'd0);
    check("rst_mux_b_sel",  {31'd0, bus2.mux_b_sel}, 32'd0);
    check("rst_busy",       {31'd0, bus2.busy}, 32'd0);

    // First tie after reset goes to fetch, then the held load.
    sq[0].push_back('{1'b1, 1'b0, 1'b0, 32'h0000_0200, 2});
    sq[0].push_back('{1'b0, 1'b1, 1'b0, 32'h0000_0300, 2});
    rst2_n = 1'b1;
    fork
      fetch_job(32'h0000_0200, wf1);
      data_job(0, 32'h0000_0300, 1'b0, 32'd0, wd1);
    join
    check("post_rst_fetch_first", wf1, 3);
    check("post_rst_data_second", wd1, 7);
    repeat (2) @(negedge clk);

    // Fetch read, MEM_LAT=2: done at cycle 3, address holds in IDLE afterwards.
    sq[0].push_back('{1'b1, 1'b0, 1'b0, 32'h0000_0040, 2});
    fetch_job(32'h0000_0040, wf1);
    check("fetch_cycles", wf1, 3);
    @(negedge clk);
    check("idle_addr_hold", bus2.mem_addr, 32'h0000_0040);
    check("idle_busy", {31'd0, bus2.busy}, 32'd0);
    @(negedge clk);

    // Load, MEM_LAT=2.
    sq[0].push_back('{1'b0, 1'b1, 1'b0, 32'h0000_0100, 2});
    data_job(0, 32'h0000_0100, 1'b0, 32'd0, wd1);
    check("load_cycles", wd1, 3);
    repeat (2) @(negedge clk);

    // Store: one write cycle, done at cycle 2.
    sq[0].push_back('{1'b0, 1'b0, 1'b1, 32'h0000_0104, 1});
    wq[0].push_back('{32'h0000_0104, 32'hDEAD_BEEF});
    data_job(0, 32'h0000_0104, 1'b1, 32'hDEAD_BEEF, wd1);
    check("store_cycles", wd1, 2);
    repeat (2) @(negedge clk);

    // Tie right after a fetch: data wins.
    sq[0].push_back('{1'b1, 1'b0, 1'b0, 32'h0000_0044, 2});
    fetch_job(32'h0000_0044, wf1);
    repeat (2) @(negedge clk);
    sq[0].push_back('{1'b0, 1'b1, 1'b0, 32'h0000_0108, 2});
    sq[0].push_back('{1'b1, 1'b0, 1'b0, 32'h0000_0048, 2});
    fork
      data_job(0, 32'h0000_0108, 1'b0, 32'd0, wd1);
      fetch_job(32'h0000_0048, wf1);
    join
    check("tie_after_fetch_data", wd1, 3);
    check("tie_after_fetch_fetch", wf1, 7);
    repeat (2) @(negedge clk);

    // Store alone so data was served last.
    sq[0].push_back('{1'b0, 1'b0, 1'b1, 32'h0000_010C, 1});
    wq[0].push_back('{32'h0000_010C, 32'h1234_5678});
    data_job(0, 32'h0000_010C, 1'b1, 32'h1234_5678, wd1);
    repeat (2) @(negedge clk);

    // Contention: both sides keep requesting; grants alternate.
    sq[0].push_back('{1'b1, 1'b0, 1'b0, 32'h0000_0050, 2});
    sq[0].push_back('{1'b0, 1'b0, 1'b1, 32'h0000_0110, 1});
    sq[0].push_back('{1'b1, 1'b0, 1'b0, 32'h0000_0054, 2});
    sq[0].push_back('{1'b0, 1'b1, 1'b0, 32'h0000_0114, 2});
    wq[0].push_back('{32'h0000_0110, 32'hCAFE_F00D});
    fork
      begin
        fetch_job(32'h0000_0050, wf1);
        repeat (2) @(negedge clk);
        fetch_job(32'h0000_0054, wf2);
      end
      begin
        data_job(0, 32'h0000_0110, 1'b1, 32'hCAFE_F00D, wd1);
        repeat (2) @(negedge clk);
        data_job(0, 32'h0000_0114, 1'b0, 32'd0, wd2);
      end
    join
    check("cont_fetch1", wf1, 3);
    check("cont_store1", wd1, 6);
    check("cont_fetch2", wf2, 5);
    check("cont_load2",  wd2, 6);
    repeat (2) @(negedge clk);

    // Mid-access reset on the MEM_LAT=3 instance, then a clean re-request.
    rst3_n = 1'b1;
    repeat (2) @(negedge clk);
    sq[1].push_back('{1'b0, 1'b1, 1'b0, 32'h0000_0180, 3});
    bus3.data_addr = 32'h0000_0180; bus3.data_we = 1'b0; bus3.req_data = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", {31'd0, bus3.busy}, 32'd1);
    rst3_n = 1'b0;
    bus3.req_data = 1'b0;
    @(negedge clk);
    check("abort_mem_addr",  bus3.mem_addr, 32'd0);
    check("abort_busy",      {31'd0, bus3.busy}, 32'd0);
    check("abort_done_data", {31'd0, bus3.done_data}, 32'd0);
    sq[1].delete();
    rst3_n = 1'b1;
    @(negedge clk);
    sq[1].push_back('{1'b0, 1'b1, 1'b0, 32'h0000_0180, 3});
    data_job(1, 32'h0000_0180, 1'b0, 32'd0, wd1);
    check("rereq_cycles", wd1, 4);

    repeat (6) @(negedge clk);
    check("sq0_drained", sq[0].size(), 0);
    check("sq1_drained", sq[1].size(), 0);
    check("wq0_drained", wq[0].size(), 0);
    check("wq1_drained", wq[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
